fifo_rr_arbiter: RTL
====================

# fifo_rr_arbiter

Round-robin read arbiter that drains NUM_QUEUES first-word-fall-through FIFOs, such as the hash-request FIFOs in front of the table, into one shared downstream consumer. Each cycle it picks at most one non-empty FIFO and pops it. The popped word goes into a single output register with a valid/ready handshake and a source-index tag. A configurable burst limit lets one queue hold the grant for up to MAX_BURST consecutive words before priority rotates.

## Interface
- NUM_QUEUES, 4: number of upstream FIFOs; legal range is 2 or more.
- DATA_WIDTH, 8: word width of every FIFO.
- MAX_BURST, 1: maximum consecutive grants to one queue before rotation; 1 gives pure round robin; legal range is 1 or more.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  when low, no new grants are made; a held output word stays presented.
- q_empty  in  NUM_QUEUES  per-FIFO empty flag.
- q_data  in  NUM_QUEUES*DATA_WIDTH  flattened FIFO data_out; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; valid while q_empty[i] is low.
- q_rd_en  out  NUM_QUEUES  one-hot-or-zero pop strobes, combinational.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_WIDTH  registered word.
- out_src  out  SRC_WIDTH  index of the queue the word came from.
- out_ready  in  1  consumer accepts the word on a cycle where out_valid and out_ready are both high.

## Operation
- Internal state:
  - ptr (SRC_WIDTH): current priority index.
  - burst_cnt: counts 0 to MAX_BURST-1.
  - the output register.
- load = !out_valid || out_ready.
- Request vector: req = ~q_empty, qualified by enable.
- Winner w: the first index with req set, searching from ptr upward and wrapping modulo NUM_QUEUES.
- A grant happens when load is high and any req bit is set. On a grant:
  - q_rd_en[w] = 1; all other bits are 0.
  - Next edge: out_data = q_data[w], out_src = w, out_valid = 1.
  - Burst update: cnt_n = (w == ptr) ? burst_cnt+1 : 1.
    - If cnt_n == MAX_BURST: ptr = (w+1) mod NUM_QUEUES, burst_cnt = 0.
    - Otherwise: ptr = w, burst_cnt = cnt_n.
- When load is high and there is no grant:
  - out_valid = 0 on the next edge.
  - out_data and out_src hold their values.
  - ptr and burst_cnt are unchanged.
- When load is low:
  - q_rd_en = 0.
  - Output register, ptr and burst_cnt are unchanged; out_data is held stable while stalled.
- q_rd_en is never asserted for an empty queue, and never while reset is high.
- Conceptual states: EMPTY (out_valid=0) and HOLD (out_valid=1).
  - EMPTY to HOLD on a grant.
  - HOLD to HOLD on a grant (accept and refill in the same cycle) or on a stall (out_ready=0).
  - HOLD to EMPTY on accept with no grant.

## Timing
- Reset values, forced asynchronously:
  - out_valid=0, out_data=0, out_src=0.
  - ptr=0, burst_cnt=0.
  - q_rd_en=0 combinationally while reset is high.
- Latency: q_rd_en[w] in cycle N; out_valid, out_data and out_src reflect w from edge N+1.
- Throughput: one word per cycle with out_ready held high and at least one queue non-empty.
- A stall never drops or duplicates a word; exactly one pop per accepted-or-initial load.
- Reset asserted mid-stream: the held output word is discarded, and no pop is issued in the reset cycle.
- enable deasserted while in HOLD: the word stays until it is accepted, then out_valid falls.
- SRC_WIDTH = max(1, clog2(NUM_QUEUES)).
- ptr wraps from NUM_QUEUES-1 to 0.
- burst_cnt width = max(1, clog2(MAX_BURST)).

## Structure
- Package fifo_arb_pkg:
  - clog2 function.
  - SRC_WIDTH and BURST_WIDTH derivation functions.
- Sub-module rr_priority_picker: purely combinational; inputs req[NUM_QUEUES] and ptr; outputs winner index and any_req. Implement as a doubled-vector masked priority search; no loops with data-dependent exit.
- Top level holds the output register, ptr/burst update and the q_rd_en decode.

## Test plan
- Reset, then set q_empty=4'b1111 -> q_rd_en=0 and out_valid=0 for 10 cycles; then q_empty=4'b1110 with q_data[0]=8'hA5 -> q_rd_en=4'b0001 and the next cycle out_data=A5, out_src=0.
- All four queues non-empty, MAX_BURST=1, out_ready=1 -> grants in order 0,1,2,3,0,… with one word per cycle.
- MAX_BURST=3, queues 0 and 2 each hold 5 words -> out_src sequence is 0,0,0,2,2,2,0,0,2,2.
- out_ready=0 for 4 cycles while in HOLD -> q_rd_en=0, and out_data/out_src stay stable; on release the next grant follows the RR order with no word lost.
- ptr=3, only queue 1 non-empty -> wrap-around grant to 1, then ptr=2.
- Reset pulsed asynchronously mid-burst -> outputs are immediately zero, q_rd_en=0; after release, grants restart at queue 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO round-robin arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int src_width(input int num_queues);
    return (clog2(num_queues) < 1) ? 1 : clog2(num_queues);
  endfunction

  function automatic int burst_width(input int max_burst);
    return (clog2(max_burst) < 1) ? 1 : clog2(max_burst);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotating-priority winner search
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  localparam int SRC_WIDTH = src_width(NUM_QUEUES)
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [SRC_WIDTH-1:0]  ptr,
  output logic [SRC_WIDTH-1:0]  winner,
  output logic                  any_req
);

  logic [2*NUM_QUEUES-1:0] req_dbl;
  logic [2*NUM_QUEUES-1:0] masked;
  logic [2*NUM_QUEUES-1:0] lowest;

  // Upper copy of req always lies above ptr, so the masked search never misses a requester.
  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    for (int i = 0; i < 2 * NUM_QUEUES; i++) begin
      masked[i] = req_dbl[i] & (i >= int'(ptr));
    end
    lowest = masked & (~masked + 1'b1);
  end

  always_comb begin
    winner = '0;
    for (int i = 0; i < 2 * NUM_QUEUES; i++) begin
      if (lowest[i]) winner = winner | SRC_WIDTH'(i % NUM_QUEUES);
    end
    any_req = |req;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst arbiter draining FWFT FIFOs into one output register
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 1,
  localparam int SRC_WIDTH = src_width(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_QUEUES-1:0]            q_empty,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_data,
  output logic [NUM_QUEUES-1:0]            q_rd_en,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SRC_WIDTH-1:0]             out_src,
  input  logic                             out_ready
);

  localparam int BURST_WIDTH = burst_width(MAX_BURST);

  arb_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SRC_WIDTH-1:0]   src_q, src_d;
  logic [SRC_WIDTH-1:0]   ptr_q, ptr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH:0]   cnt_n;

  logic [NUM_QUEUES-1:0]  req;
  logic [SRC_WIDTH-1:0]   winner;
  logic                   any_req;
  logic                   load;
  logic                   grant;

  assign req   = enable ? ~q_empty : '0;
  assign load  = (state_q == ST_EMPTY) || out_ready;
  assign grant = load && any_req && !reset;

  rr_priority_picker #(
    .NUM_QUEUES(NUM_QUEUES)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any_req(any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  // cnt_n carries one extra bit so reaching MAX_BURST never wraps before the compare.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    cnt_n   = (winner == ptr_q) ? ({1'b0, burst_q} + 1'b1) : (BURST_WIDTH + 1)'(1);
    if (load) begin
      if (any_req) begin
        state_d = ST_HOLD;
        data_d  = q_data[winner*DATA_WIDTH +: DATA_WIDTH];
        src_d   = winner;
        if (cnt_n == (BURST_WIDTH + 1)'(MAX_BURST)) begin
          ptr_d   = (winner == SRC_WIDTH'(NUM_QUEUES - 1)) ? '0 : winner + 1'b1;
          burst_d = '0;
        end else begin
          ptr_d   = winner;
          burst_d = cnt_n[BURST_WIDTH-1:0];
        end
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_comb begin
    q_rd_en = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      q_rd_en[i] = grant && (winner == SRC_WIDTH'(i));
    end
    out_valid = (state_q == ST_HOLD);
    out_data  = data_q;
    out_src   = src_q;
  end

endmodule
